multilane_os_receive: RTL



---
 rtl/multilane_os_receive.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/multilane_os_receive.sv
// Multilane ordered-set receiver: per-lane byte-sliding alignment of Gen3/Gen4
// training ordered sets with debounced one-shot reporting, plus data-mode forwarding.
module multilane_os_receive #(
  parameter int LANES       = 2,
  parameter int MATCH_COUNT = 2,
  parameter int CNT_W       = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lane_rx_on,
  input  logic [3:0]         d_sel,
  input  logic               data_os,
  input  logic [LANES*8-1:0] lane_rx,
  output logic [LANES*4-1:0] os_in,
  output logic [LANES-1:0]   os_lock,
  output logic [LANES*8-1:0] transport_layer_data_out,
  output logic               data_valid
);

  localparam logic [CNT_W-1:0] MATCH_MAX = CNT_W'(MATCH_COUNT);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [3:0]       OS_NONE   = 4'h9;

  function automatic logic os_match(input logic [3:0] sel, input logic [63:0] win,
                                    input logic [7:0] lane);
    logic m;
    case (sel)
      4'd2:    m = (win == {8'h01, lane, 48'h0000_0400_98F2});
      4'd3:    m = (win == {8'h01, lane, 48'h0000_0400_64F2});
      4'd5:    m = (win[31:0] == 32'h7E04_B0F0);
      4'd6:    m = (win[31:0] == 32'h7E06_90F0);
      4'd7:    m = (win[31:0] == 32'h7E0F_0F00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

  logic [3:0]         d_sel_r;
  logic               os_sel_s;
  logic               hold_s;
  logic               data_mode_s;
  logic [2:0]         last_s;
  logic [LANES*8-1:0] data_out_r;
  logic               data_valid_r;

  // Decode the selected ordered set: is it one we align to, and what is its period.
  always_comb begin
    os_sel_s = 1'b0;
    last_s   = 3'd3;
    case (d_sel)
      4'd2, 4'd3: begin
        os_sel_s = 1'b1;
        last_s   = 3'd7;
      end
      4'd5, 4'd6, 4'd7: begin
        os_sel_s = 1'b1;
        last_s   = 3'd3;
      end
      default: begin
        os_sel_s = 1'b0;
        last_s   = 3'd3;
      end
    endcase
    data_mode_s = (d_sel == 4'd8);
    hold_s      = !os_sel_s || (d_sel != d_sel_r);
  end

  // d_sel history follows the input even in reset, so leaving reset is never a "change".
  always_ff @(posedge clk) begin
    d_sel_r <= d_sel;
  end

  // Data-mode forwarding to the transport layer.
  always_ff @(posedge clk) begin
    if (!rst || !lane_rx_on) begin
      data_out_r   <= {(LANES*8){1'b0}};
      data_valid_r <= 1'b0;
    end else begin
      data_valid_r <= data_mode_s && data_os;
      if (data_mode_s && data_os) begin
        data_out_r <= lane_rx;
      end
    end
  end

  assign transport_layer_data_out = data_out_r;
  assign data_valid               = data_valid_r;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // Only 56 bits are stored: the oldest byte of the window is consumed by this compare.
    logic [55:0]      sh_r;
    logic [63:0]      win_s;
    logic [2:0]       bcnt_r;
    logic [CNT_W-1:0] mcnt_r;
    logic [CNT_W-1:0] mcnt_inc_s;
    logic             locked_r;
    logic             sent_r;
    logic             match_s;
    logic             wrap_s;
    logic [3:0]       os_in_r;

    // Next-state window, pattern compare and saturating match count.
    always_comb begin
      win_s   = {sh_r, lane_rx[8*i +: 8]};
      match_s = os_match(d_sel, win_s, 8'(i));
      wrap_s  = (bcnt_r == last_s);
      if (mcnt_r >= MATCH_MAX) begin
        mcnt_inc_s = MATCH_MAX;
      end else begin
        mcnt_inc_s = mcnt_r + CNT_ONE;
      end
    end

    // Per-lane UNLOCKED/LOCKED alignment and one-shot code reporting.
    always_ff @(posedge clk) begin
      if (!rst || !lane_rx_on) begin
        sh_r     <= 56'h0;
        bcnt_r   <= 3'd0;
        mcnt_r   <= CNT_ZERO;
        locked_r <= 1'b0;
        sent_r   <= 1'b0;
        os_in_r  <= OS_NONE;
      end else begin
        sh_r    <= win_s[55:0];
        os_in_r <= OS_NONE;
        if (hold_s) begin
          locked_r <= 1'b0;
          bcnt_r   <= 3'd0;
          mcnt_r   <= CNT_ZERO;
          sent_r   <= 1'b0;
        end else if (!locked_r) begin
          if (match_s) begin
            locked_r <= 1'b1;
            bcnt_r   <= 3'd0;
            mcnt_r   <= CNT_ONE;
            if (MATCH_MAX == CNT_ONE && !sent_r) begin
              os_in_r <= d_sel;
              sent_r  <= 1'b1;
            end
          end
        end else if (!wrap_s) begin
          bcnt_r <= bcnt_r + 3'd1;
        end else begin
          bcnt_r <= 3'd0;
          if (match_s) begin
            mcnt_r <= mcnt_inc_s;
            if (mcnt_inc_s == MATCH_MAX && !sent_r) begin
              os_in_r <= d_sel;
              sent_r  <= 1'b1;
            end
          end else begin
            locked_r <= 1'b0;
            mcnt_r   <= CNT_ZERO;
            sent_r   <= 1'b0;
          end
        end
      end
    end

    assign os_in[4*i +: 4] = os_in_r;
    assign os_lock[i]      = locked_r;
  end

endmodule
